// File: rtl/fft4_seq_ctrl.sv
// fft4_seq_ctrl
//   Sequential 4-point radix-2 DIF FFT controller. It collects four complex
//   samples, steps them through an external shared butterfly in four cycles,
//   and then streams the bins out in natural order y0..y3.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input sample handshake; in_re/in_im carry x0..x3
//   out_valid/out_ready      output bin handshake; out_re/out_im carry the bin
//   out_idx                  bin index of the bin being presented
//   out_last                 high with y3
//   busy                     high unless idle in LOAD with no samples held
//   bf_a_*, bf_b_*, bf_w_*   operands to the external butterfly
//   bf_p_*, bf_q_*           butterfly results p = a + w*b, q = a - w*b
module fft4_seq_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic [1:0]    out_idx,
  output logic          out_last,
  output logic          busy,
  output logic [DW-1:0] bf_a_re,
  output logic [DW-1:0] bf_a_im,
  output logic [DW-1:0] bf_b_re,
  output logic [DW-1:0] bf_b_im,
  output logic [DW-1:0] bf_w_re,
  output logic [DW-1:0] bf_w_im,
  input  logic [DW-1:0] bf_p_re,
  input  logic [DW-1:0] bf_p_im,
  input  logic [DW-1:0] bf_q_re,
  input  logic [DW-1:0] bf_q_im
);

  typedef enum logic [2:0] {
    LOAD,
    BF0,
    BF1,
    BF2,
    BF3,
    OUT
  } state_t;

  state_t state, state_nx;

  logic [1:0]    ld_cnt;
  logic [1:0]    rd_cnt;
  logic [DW-1:0] slot_re [4];
  logic [DW-1:0] slot_im [4];

  // Butterfly routing: which slots feed a/b and receive p/q this cycle.
  logic          bf_en;
  logic [1:0]    a_idx;
  logic [1:0]    b_idx;
  logic          w_neg_j;
  logic [1:0]    rd_slot;

  // After the DIF passes the slots hold y0,y2,y1,y3; reading slot at the
  // bit-reversed index of rd_cnt restores natural bin order.
  assign rd_slot = {rd_cnt[0], rd_cnt[1]};

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_re    = '0;
    out_im    = '0;
    bf_en     = 1'b0;
    a_idx     = 2'd0;
    b_idx     = 2'd0;
    w_neg_j   = 1'b0;

    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (ld_cnt == 2'd3)) begin
          state_nx = BF0;
        end
      end
      BF0: begin
        bf_en    = 1'b1;
        a_idx    = 2'd0;
        b_idx    = 2'd2;
        state_nx = BF1;
      end
      BF1: begin
        bf_en    = 1'b1;
        a_idx    = 2'd1;
        b_idx    = 2'd3;
        state_nx = BF2;
      end
      BF2: begin
        bf_en    = 1'b1;
        a_idx    = 2'd0;
        b_idx    = 2'd1;
        state_nx = BF3;
      end
      BF3: begin
        bf_en    = 1'b1;
        a_idx    = 2'd2;
        b_idx    = 2'd3;
        w_neg_j  = 1'b1;
        state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_idx   = rd_cnt;
        out_last  = (rd_cnt == 2'd3);
        out_re    = slot_re[rd_slot];
        out_im    = slot_im[rd_slot];
        if (out_ready && (rd_cnt == 2'd3)) begin
          state_nx = LOAD;
        end
      end
      default: begin
        state_nx = LOAD;
      end
    endcase
  end

  assign busy = !((state == LOAD) && (ld_cnt == 2'd0));

  // Operands are forced to a=b=0, w=(1,0) whenever no butterfly is scheduled.
  always_comb begin
    bf_a_re = '0;
    bf_a_im = '0;
    bf_b_re = '0;
    bf_b_im = '0;
    bf_w_re = DW'(1);
    bf_w_im = '0;
    if (bf_en) begin
      bf_a_re = slot_re[a_idx];
      bf_a_im = slot_im[a_idx];
      bf_b_re = slot_re[b_idx];
      bf_b_im = slot_im[b_idx];
      if (w_neg_j) begin
        bf_w_re = '0;
        bf_w_im = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      ld_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      state <= state_nx;
      // Both counters are two bits wide, so the 3->0 step on the last
      // handshake of a frame comes from natural wrap.
      if (in_valid && in_ready) begin
        ld_cnt <= ld_cnt + 2'd1;
      end
      if (out_valid && out_ready) begin
        rd_cnt <= rd_cnt + 2'd1;
      end
    end
  end

  // Sample storage carries no reset; a reset abandons the frame through the
  // control state alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        slot_re[ld_cnt] <= in_re;
        slot_im[ld_cnt] <= in_im;
      end
      if (bf_en) begin
        slot_re[a_idx] <= bf_p_re;
        slot_im[a_idx] <= bf_p_im;
        slot_re[b_idx] <= bf_q_re;
        slot_im[b_idx] <= bf_q_im;
      end
    end
  end

endmodule
